// File: rtl/nios_qsys_cpu_div_pkg.sv
// nios_qsys_cpu_div_pkg
// Shared definitions for the iterative divider cell:
//   DATA_W     - operand/result width (the datapath only supports 32)
//   ITERATIONS - number of restoring steps per divide (one per result bit)
//   LAST_ITER  - counter value seen during the final step
//   div_state_e - controller states
package nios_qsys_cpu_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ITERATIONS = 32;

    // The 6-bit iteration counter reads this value while the last step executes.
    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nios_qsys_cpu_nios_div_step.sv
// nios_qsys_cpu_nios_div_step
// One combinational radix-2 restoring division step on unsigned magnitudes.
// Ports:
//   rem_in  - partial remainder entering the step (always < divisor)
//   dvd_in  - remaining dividend bits; quotient bits accumulate in the low end
//   divisor - unsigned divisor magnitude
//   rem_out - partial remainder after the step
//   dvd_out - dividend bits shifted left with the new quotient bit appended
//   q_bit   - quotient bit produced by this step
module nios_qsys_cpu_nios_div_step
    import nios_qsys_cpu_div_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] dvd_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] dvd_out,
    output logic              q_bit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff_low;

    // Shift remainder:dividend left by one and try the subtraction.
    // The shifted value can reach 33 bits, so the compare uses all of them.
    // When the subtraction succeeds the true difference is below the divisor,
    // so a 32-bit subtract of the low bits is exact.
    always_comb begin
        shifted  = {rem_in, dvd_in[DATA_W-1]};
        diff_low = shifted[DATA_W-1:0] - divisor;
        q_bit    = (shifted >= {1'b0, divisor});
        rem_out  = q_bit ? diff_low : shifted[DATA_W-1:0];
        dvd_out  = {dvd_in[DATA_W-2:0], q_bit};
    end

endmodule

// File: rtl/nios_qsys_cpu_nios_div_cell.sv
// nios_qsys_cpu_nios_div_cell
// Fixed-latency iterative 32-bit divider, signed or unsigned.
// A request in IDLE loads operand magnitudes, 32 restoring steps run in CALC,
// FIX applies signs and registers the result, DONE pulses M_div_done.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   M_div_start           - one-cycle request, honoured only in IDLE
//   M_div_signed          - 1 = two's-complement operands
//   M_div_src1/src2       - dividend / divisor
//   M_div_busy            - high from the cycle after acceptance through DONE
//   M_div_done            - one-cycle pulse, results valid
//   M_div_cell_quotient   - quotient, held until the next FIX
//   M_div_cell_remainder  - remainder, sign follows the dividend
module nios_qsys_cpu_nios_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M_div_start,
    input  logic              M_div_signed,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_cell_quotient,
    output logic [DATA_W-1:0] M_div_cell_remainder
);

    import nios_qsys_cpu_div_pkg::*;

    div_state_e state_q;
    div_state_e state_d;

    logic [5:0]        count_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W-1:0] src1_q;
    logic              quot_neg_q;
    logic              rem_neg_q;
    logic              div_zero_q;

    logic [DATA_W-1:0] src1_abs;
    logic [DATA_W-1:0] src2_abs;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_dvd;
    logic              step_q_bit;

    // Operand magnitudes; unsigned requests pass straight through.
    always_comb begin
        src1_abs = M_div_src1;
        src2_abs = M_div_src2;
        if (M_div_signed && M_div_src1[DATA_W-1]) begin
            src1_abs = -M_div_src1;
        end
        if (M_div_signed && M_div_src2[DATA_W-1]) begin
            src2_abs = -M_div_src2;
        end
    end

    nios_qsys_cpu_nios_div_step u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .dvd_out (step_dvd),
        .q_bit   (step_q_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Starts outside IDLE are dropped, never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (M_div_start) state_d = CALC;
            CALC: if (count_q == LAST_ITER) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        M_div_busy = (state_q != IDLE);
        M_div_done = (state_q == DONE);
    end

    // Datapath. Sign handling is decided at capture so only two flags survive.
    // The quotient bits are unused by the step logic, so the step shifts them
    // into the dividend register as the dividend bits shift out.
    // Divide by zero bypasses sign fixing: quotient all ones, remainder the
    // original dividend, regardless of mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q              <= '0;
            rem_q                <= '0;
            dvd_q                <= '0;
            divisor_q            <= '0;
            src1_q               <= '0;
            quot_neg_q           <= 1'b0;
            rem_neg_q            <= 1'b0;
            div_zero_q           <= 1'b0;
            M_div_cell_quotient  <= '0;
            M_div_cell_remainder <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (M_div_start) begin
                        count_q    <= '0;
                        rem_q      <= '0;
                        dvd_q      <= src1_abs;
                        divisor_q  <= src2_abs;
                        src1_q     <= M_div_src1;
                        quot_neg_q <= M_div_signed &
                                      (M_div_src1[DATA_W-1] ^ M_div_src2[DATA_W-1]);
                        rem_neg_q  <= M_div_signed & M_div_src1[DATA_W-1];
                        div_zero_q <= (M_div_src2 == '0);
                    end
                end
                CALC: begin
                    rem_q   <= step_rem;
                    dvd_q   <= step_dvd;
                    count_q <= count_q + 6'd1;
                end
                FIX: begin
                    if (div_zero_q) begin
                        M_div_cell_quotient  <= '1;
                        M_div_cell_remainder <= src1_q;
                    end else begin
                        M_div_cell_quotient  <= quot_neg_q ? -dvd_q : dvd_q;
                        M_div_cell_remainder <= rem_neg_q  ? -rem_q : rem_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_qsys_cpu_nios_div_cell.sv
// tb_nios_qsys_cpu_nios_div_cell
// Scoreboard bench: stimulus pushes the hand-computed result and the cycle in
// which M_div_done must appear; a negedge monitor pops and compares on done.
module tb_nios_qsys_cpu_nios_div_cell;

    typedef struct {
        logic [31:0] quotient;
        logic [31:0] remainder;
        int          due;
    } expected_t;

    typedef struct {
        logic        sgn;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] quotient;
        logic [31:0] remainder;
    } vector_t;

    logic        clk;
    logic        reset;
    logic        M_div_start;
    logic        M_div_signed;
    logic [31:0] M_div_src1;
    logic [31:0] M_div_src2;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_cell_quotient;
    logic [31:0] M_div_cell_remainder;

    expected_t   exp_q[$];
    int          cycle_cnt;
    int          checks;
    int          errors;
    logic [31:0] last_q;
    logic [31:0] last_r;

    nios_qsys_cpu_nios_div_cell #(.DATA_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .M_div_start          (M_div_start),
        .M_div_signed         (M_div_signed),
        .M_div_src1           (M_div_src1),
        .M_div_src2           (M_div_src2),
        .M_div_busy           (M_div_busy),
        .M_div_done           (M_div_done),
        .M_div_cell_quotient  (M_div_cell_quotient),
        .M_div_cell_remainder (M_div_cell_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to time the done pulse.
    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Called at a negedge; the start is sampled on the following posedge.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] q,
                                 input logic [31:0] r, input bit expect_it);
        expected_t e;
        M_div_start  = 1'b1;
        M_div_signed = sgn;
        M_div_src1   = a;
        M_div_src2   = b;
        @(negedge clk);
        M_div_start = 1'b0;
        if (expect_it) begin
            e.quotient  = q;
            e.remainder = r;
            e.due       = cycle_cnt + 33;
            exp_q.push_back(e);
            last_q = q;
            last_r = r;
            checkOutput("busy_cycle1", {31'd0, M_div_busy}, 32'd1);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checkOutput("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        checkOutput("busy_after_done", {31'd0, M_div_busy}, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && M_div_done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                expected_t e;
                e = exp_q.pop_front();
                checkOutput("quotient", M_div_cell_quotient, e.quotient);
                checkOutput("remainder", M_div_cell_remainder, e.remainder);
                checkOutput("done_cycle", 32'(cycle_cnt), 32'(e.due));
                checkOutput("busy_at_done", {31'd0, M_div_busy}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    vector_t vectors[10];

    initial begin
        vectors[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vectors[1] = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
        vectors[2] = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vectors[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vectors[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        vectors[5] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vectors[6] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};
        vectors[7] = '{1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF};
        vectors[8] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vectors[9] = '{1'b0, 32'd1000,      32'd3,         32'd333,       32'd1};

        checks       = 0;
        errors       = 0;
        last_q       = '0;
        last_r       = '0;
        reset        = 1'b1;
        M_div_start  = 1'b0;
        M_div_signed = 1'b0;
        M_div_src1   = '0;
        M_div_src2   = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_quotient", M_div_cell_quotient, 32'd0);
        checkOutput("reset_remainder", M_div_cell_remainder, 32'd0);
        checkOutput("reset_busy", {31'd0, M_div_busy}, 32'd0);
        checkOutput("reset_done", {31'd0, M_div_done}, 32'd0);

        // Release reset and start on the very next rising edge.
        reset = 1'b0;
        applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        waitIdle();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].sgn, vectors[i].src1, vectors[i].src2,
                          vectors[i].quotient, vectors[i].remainder, 1'b1);
            waitIdle();
        end

        // Second start while busy must be dropped; outputs hold meanwhile.
        applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
        repeat (9) @(negedge clk);
        applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        checkOutput("hold_quotient", M_div_cell_quotient, last_q);
        checkOutput("hold_remainder", M_div_cell_remainder, last_r);
        waitIdle();
        repeat (40) @(negedge clk);
        checkOutput("idle_after_ignored", {31'd0, M_div_busy}, 32'd0);

        // Reset mid-divide aborts; no done may follow.
        applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_quotient", M_div_cell_quotient, 32'd0);
        checkOutput("abort_remainder", M_div_cell_remainder, 32'd0);
        checkOutput("abort_busy", {31'd0, M_div_busy}, 32'd0);
        checkOutput("abort_done", {31'd0, M_div_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle", {31'd0, M_div_busy}, 32'd0);
        applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b1);
        waitIdle();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
